// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a start/done handshake and synchronous kill.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_TOP = CW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic [2:0]        op;
    logic              neg_res, neg_rem;
    logic [XLEN-1:0]   ma, mb;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   rem;
    logic [CW-1:0]     cnt;

    logic              accept, a_sgn, b_sgn, div_zero, ovf, special;
    logic [XLEN-1:0]   abs_a, abs_b, special_res;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    assign accept = (state == IDLE || state == DONE) && start && !kill;
    assign busy   = (state == CALC) || (state == FIX);
    assign done   = (state == DONE);

    // Signed operands: a for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM.
    assign a_sgn = a[XLEN-1] & (func3 == 3'b001 || func3 == 3'b010 ||
                                func3 == 3'b100 || func3 == 3'b110);
    assign b_sgn = b[XLEN-1] & (func3 == 3'b001 || func3 == 3'b100 ||
                                func3 == 3'b110);
    assign abs_a = a_sgn ? -a : a;
    assign abs_b = b_sgn ? -b : b;

    assign div_zero    = func3[2] && (b == '0);
    assign ovf         = func3[2] && !func3[0] && (a == MOST_NEG) && (b == '1);
    assign special     = div_zero || ovf;
    assign special_res = div_zero ? (func3[1] ? a : '1) : (func3[1] ? '0 : a);

    // Multiply: low half of prod holds the remaining multiplier bits,
    // high half accumulates; one right shift per cycle.
    assign mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, ma} : '0);

    // Divide: dividend bits leave the top of prod's low half while quotient
    // bits enter at the bottom.
    assign div_sh   = {rem, prod[XLEN-1]};
    assign div_diff = div_sh - {1'b0, mb};
    assign div_ok   = !div_diff[XLEN];

    assign prod_fix = neg_res ? -prod : prod;
    assign quo_fix  = neg_res ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    assign rem_fix  = neg_rem ? -rem : rem;

    always_comb begin
        fix_res = rem_fix;
        case (op)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: state_nxt = start ? (special ? DONE : CALC) : IDLE;
                CALC:       if (cnt == '0) state_nxt = FIX;
                FIX:        state_nxt = DONE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op      <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            ma      <= '0;
            mb      <= '0;
            prod    <= '0;
            rem     <= '0;
            cnt     <= '0;
            result  <= '0;
        end else if (accept) begin
            op      <= func3;
            neg_res <= a_sgn ^ b_sgn;
            neg_rem <= a_sgn;
            ma      <= abs_a;
            mb      <= abs_b;
            prod    <= {{XLEN{1'b0}}, func3[2] ? abs_a : abs_b};
            rem     <= '0;
            cnt     <= CNT_TOP;
            if (special) result <= special_res;
        end else if (!kill) begin
            case (state)
                CALC: begin
                    if (op[2]) begin
                        rem  <= div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
                        prod <= {prod[2*XLEN-1:XLEN], prod[XLEN-2:0], div_ok};
                    end else begin
                        prod <= {mul_sum, prod[XLEN-1:1]};
                    end
                    cnt <= cnt - CNT_ONE;
                end
                FIX:     result <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed and random bench for muldiv_iter: expected results queued at issue,
// compared at the done pulse together with the observed latency.
module tb_muldiv_iter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst, start, kill;
    logic [2:0]      func3;
    logic [XLEN-1:0] a, b;
    logic            busy, done;
    logic [XLEN-1:0] result;

    int checks   = 0;
    int failures = 0;
    logic [XLEN-1:0] exp_q[$];

    muldiv_iter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .func3(func3),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] ex);
        checks++;
        assert (obs === ex) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'b0, x});
        longint uy = longint'({32'b0, y});
        logic [63:0] p;
        case (f)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: return (y == 0) ? 32'hFFFF_FFFF : 32'(sx / sy);
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : 32'(ux / uy);
            3'd6: return (y == 0) ? x : 32'(sx % sy);
            default: return (y == 0) ? x : 32'(ux % uy);
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return 1;
        return XLEN + 2;
    endfunction

    // Drives one accept cycle; afterwards the bench sits in cycle 1.
    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ex, input bit track);
        func3 = f; a = x; b = y; start = 1'b1;
        if (track) exp_q.push_back(ex);
        step();
        start = 1'b0;
        a = $urandom; b = $urandom; func3 = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done(input string tag, input int n0, input int lat_exp);
        int n = n0;
        while (!done && n < 200) begin
            step();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat_exp));
        if (exp_q.size() > 0) begin
            check(tag, 64'(result), 64'(exp_q.pop_front()));
        end else begin
            checks++;
            failures++;
            $error("FAIL %s observed=done expected=no_pending_result", tag);
        end
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        int pulses = 0;
        repeat (cycles) begin
            step();
            if (done) pulses++;
        end
        check(tag, 64'(pulses), 64'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; kill = 1'b0; func3 = '0; a = '0; b = '0;
        #1;
        check("rst_busy",   64'(busy),   64'd0);
        check("rst_done",   64'(done),   64'd0);
        check("rst_result", 64'(result), 64'd0);
        #11 rst = 1'b1;
        step();

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1);           wait_done("mul", 1, 34);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);   wait_done("mulhu", 1, 34);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);   wait_done("mulh", 1, 34);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);   wait_done("mulhsu", 1, 34);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1);           wait_done("div", 1, 34);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1);           wait_done("rem", 1, 34);
        issue(3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1);           wait_done("divu", 1, 34);
        issue(3'd7, 32'd7, 32'd3, 32'd1, 1);                           wait_done("remu", 1, 34);

        issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);                   wait_done("divu_zero", 1, 1);
        issue(3'd6, 32'd5, 32'd0, 32'd5, 1);                           wait_done("rem_zero", 1, 1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);   wait_done("div_ovf", 1, 1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);           wait_done("rem_ovf", 1, 1);

        // start during busy (cycle 10) with a special-case op must be ignored
        issue(3'd0, 32'd100, 32'd200, 32'd20000, 1);
        repeat (9) step();
        func3 = 3'd5; a = 32'd9; b = 32'd0; start = 1'b1;
        step();
        start = 1'b0;
        wait_done("ign_start", 11, 34);
        watch_quiet("ign_quiet", 40);

        // back-to-back: second start issued in the DONE cycle
        issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0), 1);
        wait_done("b2b_first", 1, 34);
        issue(3'd7, 32'd1000, 32'd7, 32'd6, 1);
        wait_done("b2b_second", 1, 34);

        // kill in cycle 12
        issue(3'd4, 32'd100, 32'd7, 32'd0, 0);
        repeat (11) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        check("kill_busy", 64'(busy), 64'd0);
        check("kill_done", 64'(done), 64'd0);
        watch_quiet("kill_quiet", 40);
        check("kill_result", 64'(result), 64'd6);

        // kill together with start in IDLE: no accept
        func3 = 3'd5; a = 32'd3; b = 32'd0; start = 1'b1; kill = 1'b1;
        step();
        start = 1'b0; kill = 1'b0;
        check("killstart_busy", 64'(busy), 64'd0);
        check("killstart_done", 64'(done), 64'd0);
        watch_quiet("killstart_quiet", 5);

        // asynchronous reset in cycle 20, between clock edges
        issue(3'd0, 32'd5, 32'd6, 32'd0, 0);
        repeat (19) step();
        #2 rst = 1'b0;
        #1;
        check("mid_rst_busy",   64'(busy),   64'd0);
        check("mid_rst_done",   64'(done),   64'd0);
        check("mid_rst_result", 64'(result), 64'd0);
        #3 rst = 1'b1;
        step();
        issue(3'd0, 32'd3, 32'd4, 32'd12, 1);
        wait_done("post_rst_mul", 1, 34);

        for (int i = 0; i < 10; i++) begin
            logic [2:0]  f;
            logic [31:0] x, y;
            f = 3'($urandom_range(0, 7));
            x = $urandom;
            y = (i % 4 == 0) ? 32'd0 : $urandom;
            if (i == 5) begin f = 3'd4; x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            issue(f, x, y, model(f, x, y), 1);
            wait_done("rnd", 1, lat_of(f, x, y));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Iterative RV32M multiply/divide unit with a start/done handshake. It extends the execute stage's single-cycle ALU with the eight M-extension operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. The operand width is parametrised and the unit computes one bit per cycle, so the control path must stall while `busy` is high. Control logic selects the unit when opcode is OP with funct7 = 0000001 and drives `func3` straight from the instruction.

## Interface
- `XLEN`, default 32: operand and result width. Must be even and at least 8.

Ports, clock and reset first:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  request a new operation. Accepted only when `busy` = 0.
- `kill`  in  1  synchronous abort of the operation in flight (pipeline flush).
- `func3`  in  3  operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a`  in  XLEN  rs1 operand: multiplicand or dividend.
- `b`  in  XLEN  rs2 operand: multiplier or divisor.
- `busy`  out  1  high in the CALC and FIX states.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  registered result. Held until the next completion.

## Operation
- States: IDLE, CALC, FIX, DONE. Reset state is IDLE.
- **Accept.** In IDLE or DONE with `start` = 1 and `kill` = 0:
  - latch `func3`, `a` and `b`;
  - record the operand signs (`a` is signed for MULH, MULHSU, DIV and REM; `b` is signed for MULH, DIV and REM);
  - load the magnitudes |a| and |b| into the working registers;
  - reset the bit counter to XLEN-1.
- **Special cases** are decided at accept. The unit goes directly to DONE with no CALC or FIX:
  - divisor = 0: DIV and DIVU return all ones; REM and REMU return `a` unchanged.
  - signed overflow (`a` = most-negative, `b` = all ones): DIV returns `a`; REM returns 0.
- **CALC** runs for XLEN cycles, one iteration per cycle.
  - Multiply: shift-add into a 2*XLEN product register. Product = |a|*|b|, unsigned.
  - Divide: restoring division, one quotient bit per cycle. Uses an (XLEN+1)-bit partial remainder; the quotient shifts into the low half.
  - The counter decrements each cycle. When the counter reaches 0, the next state is FIX.
- **FIX** lasts one cycle.
  - Negate the product when the operand signs differ; negation is two's complement over 2*XLEN bits.
  - Negate the quotient when the operand signs differ; negate the remainder when the dividend is negative.
  - Select the result:
    - MUL: product[XLEN-1:0]
    - MULH, MULHSU, MULHU: product[2*XLEN-1:XLEN]
    - DIV, DIVU: quotient
    - REM, REMU: remainder
  - Register the selected value into `result`. Next state is DONE.
- **DONE** lasts one cycle: `done` = 1, `busy` = 0. Next state is IDLE, or a new accept if `start` = 1.
- **kill** in any state: next state is IDLE. No `done` is produced and `result` keeps its previous value. `kill` overrides a simultaneous `start`.
- `start` while `busy` = 1 is ignored. There is no queueing.
- All arithmetic wraps modulo 2^XLEN, or modulo 2^(2*XLEN) for the product. No exceptions are raised.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high with `busy` low.
- Normal operation:
  - cycles 1 to XLEN: CALC;
  - cycle XLEN+1: FIX;
  - cycle XLEN+2: DONE.
  - Latency is XLEN+2, which is 34 cycles for XLEN = 32.
- Special cases: DONE in cycle 1 (latency 1).
- `busy` rises in cycle 1 and falls in cycle XLEN+2.
- Back-to-back: a `start` in the DONE cycle is accepted. Its CALC begins in the next cycle, so there are no idle bubbles.
- Reset, asserted at any time, takes effect immediately without waiting for a clock edge:
  - state = IDLE;
  - `busy` = 0, `done` = 0, `result` = 0;
  - working registers cleared.
- Deasserting reset takes effect at the next rising edge. The first `start` is accepted at that edge at the earliest.
- Operand inputs are ignored outside the accept cycle.

## Test plan
All values are for XLEN = 32.
- **Signed and unsigned multiply.**
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB, `done` exactly in cycle 34.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Division sign rules.**
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
  - REMU 7 / 3 → 1.
- **Special cases, all with `done` in cycle 1.**
  - DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- **Handshake.**
  - `start` with new operands in cycle 10 of an operation: ignored, and the first result is unaffected.
  - `start` in the DONE cycle: the second result arrives 34 cycles later.
- **Kill.**
  - `kill` in cycle 12: `busy` = 0 in cycle 13, no `done` pulse, `result` still holds the prior value.
  - `kill` and `start` together in IDLE: no accept.
- **Reset mid-operation.**
  - Assert `rst` = 0 in cycle 20, between clock edges: `busy`, `done` and `result` go to 0 immediately.
  - After release, a new MUL 3 × 4 → 12 in 34 cycles.
